// File: rtl/keypad_lock.sv
// ---------------------------------------------------------------------------
// keypad_lock : debounced 4-digit code lock with failure lockout
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_lock #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned DEBOUNCE       = 4,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [3:0] number,
  input  logic       relock,
  output logic       key_strobe,
  output logic [2:0] digit_count,
  output logic       unlocked,
  output logic       error,
  output logic       lockout,
  output logic [1:0] fail_count
);

  localparam logic [3:0] c_debounce = 4'(DEBOUNCE);
  localparam logic [2:0] c_max_fail = 3'(MAX_FAIL);
  localparam logic [7:0] c_lockout  = 8'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  number_prev_q, number_prev_d;
  logic [3:0]  press_cnt_q, press_cnt_d;
  logic [3:0]  release_cnt_q, release_cnt_d;
  logic        armed_q, armed_d;
  logic [11:0] entry_q, entry_d;
  logic [2:0]  digit_count_q, digit_count_d;
  logic [1:0]  fail_count_q, fail_count_d;
  logic [7:0]  timer_q, timer_d;
  logic        key_strobe_q, key_strobe_d;
  logic        error_q, error_d;

  logic        press_hit;
  logic        accept;
  logic        digit_ok;
  logic [15:0] candidate;

  // Debouncer: counters saturate at DEBOUNCE so a long hold never wraps.
  always_comb begin
    number_prev_d = number;
    press_cnt_d   = 4'd0;
    release_cnt_d = 4'd0;
    if (valid) begin
      if (number != number_prev_q) begin
        press_cnt_d = 4'd1;
      end else if (press_cnt_q != c_debounce) begin
        press_cnt_d = press_cnt_q + 4'd1;
      end else begin
        press_cnt_d = press_cnt_q;
      end
    end else begin
      if (release_cnt_q != c_debounce) begin
        release_cnt_d = release_cnt_q + 4'd1;
      end else begin
        release_cnt_d = release_cnt_q;
      end
    end

    // A reload-to-1 also counts as reaching the threshold when DEBOUNCE is 1.
    press_hit = valid && (press_cnt_d == c_debounce) &&
                ((press_cnt_d != press_cnt_q) || (number != number_prev_q));
    accept    = press_hit && armed_q;
    digit_ok  = accept && (number <= 4'd9);

    armed_d = armed_q;
    if (release_cnt_d == c_debounce) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    timer_d       = timer_q;
    key_strobe_d  = 1'b0;
    error_d       = 1'b0;
    candidate     = {entry_q, number};

    case (state_q)
      ST_LOCKED: begin
        if (relock) begin
          digit_count_d = 3'd0;
          entry_d       = 12'd0;
        end else if (digit_ok) begin
          key_strobe_d = 1'b1;
          if (digit_count_q != 3'd3) begin
            entry_d       = {entry_q[7:0], number};
            digit_count_d = digit_count_q + 3'd1;
          end else begin
            digit_count_d = 3'd0;
            entry_d       = 12'd0;
            if (candidate == CODE) begin
              state_d      = ST_OPEN;
              fail_count_d = 2'd0;
            end else begin
              error_d = 1'b1;
              if (({1'b0, fail_count_q} + 3'd1) == c_max_fail) begin
                state_d      = ST_LOCKOUT;
                fail_count_d = 2'd0;
                timer_d      = c_lockout;
              end else begin
                fail_count_d = fail_count_q + 2'd1;
              end
            end
          end
        end
      end

      ST_OPEN: begin
        if (relock) begin
          state_d       = ST_LOCKED;
          digit_count_d = 3'd0;
        end
      end

      ST_LOCKOUT: begin
        timer_d = timer_q - 8'd1;
        if (timer_q == 8'd1) begin
          state_d = ST_LOCKED;
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOCKED;
      number_prev_q <= 4'd0;
      press_cnt_q   <= 4'd0;
      release_cnt_q <= 4'd0;
      armed_q       <= 1'b0;
      entry_q       <= 12'd0;
      digit_count_q <= 3'd0;
      fail_count_q  <= 2'd0;
      timer_q       <= 8'd0;
      key_strobe_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      number_prev_q <= number_prev_d;
      press_cnt_q   <= press_cnt_d;
      release_cnt_q <= release_cnt_d;
      armed_q       <= armed_d;
      entry_q       <= entry_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      timer_q       <= timer_d;
      key_strobe_q  <= key_strobe_d;
      error_q       <= error_d;
    end
  end

  assign key_strobe  = key_strobe_q;
  assign digit_count = digit_count_q;
  assign unlocked    = (state_q == ST_OPEN);
  assign lockout     = (state_q == ST_LOCKOUT);
  assign error       = error_q;
  assign fail_count  = fail_count_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_lock.sv
// ---------------------------------------------------------------------------
// tb_keypad_lock : scoreboard bench for keypad_lock (directed vectors)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_keypad_lock;

  localparam int DEB = 4;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [3:0] number;
  logic       relock;
  logic       key_strobe;
  logic [2:0] digit_count;
  logic       unlocked;
  logic       error;
  logic       lockout;
  logic [1:0] fail_count;

  keypad_lock #(
    .CODE(16'h1234), .DEBOUNCE(DEB), .MAX_FAIL(3), .LOCKOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .number(number), .relock(relock),
    .key_strobe(key_strobe), .digit_count(digit_count), .unlocked(unlocked),
    .error(error), .lockout(lockout), .fail_count(fail_count)
  );

  // Expected output vector: {key_strobe, error, digit_count, unlocked, lockout, fail_count}
  typedef struct {
    logic [8:0] v;
    int         cyc;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         lo_cycles = 0;
  int         checks = 0;
  int         errors = 0;

  int         probe_req = 0;
  int         probe_ack = 0;
  int         probe_kind = 0;
  logic [8:0] probe_exp = '0;
  int         probe_int = 0;
  string      probe_name = "";

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [8:0] ev(bit ks, bit er, int dc, bit un, bit lo, int fc);
    return {ks, er, 3'(dc), un, lo, 2'(fc)};
  endfunction

  // Monitor: sole owner of the check/error counters.
  initial begin
    logic [8:0] got;
    exp_t       it;
    forever begin
      @(negedge clk);
      got = {key_strobe, error, digit_count, unlocked, lockout, fail_count};
      if (lockout) lo_cycles++;
      if (key_strobe || error) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %b at cyc %0d, required no event", got, cyc);
        end else begin
          it = sb_q.pop_front();
          if (got !== it.v || cyc != it.cyc) begin
            errors++;
            $display("FAIL %s: got %b at cyc %0d, required %b at cyc %0d",
                     it.name, got, cyc, it.v, it.cyc);
          end
        end
      end
      if (probe_req != probe_ack) begin
        probe_ack = probe_req;
        checks++;
        case (probe_kind)
          0: if (got !== probe_exp) begin
               errors++;
               $display("FAIL %s: got %b, required %b", probe_name, got, probe_exp);
             end
          1: if (lo_cycles != probe_int) begin
               errors++;
               $display("FAIL %s: got %0d, required %0d", probe_name, lo_cycles, probe_int);
             end
          3: if (sb_q.size() != 0) begin
               errors++;
               $display("FAIL %s: got %0d pending, required 0", probe_name, sb_q.size());
             end
          default: begin
            errors++;
            $display("FAIL %s: wait bound expired", probe_name);
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string n, input int k, input logic [8:0] e, input int i);
    probe_name = n;
    probe_kind = k;
    probe_exp  = e;
    probe_int  = i;
    probe_req++;
    tick();
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) tick();
  endtask

  // Hold a key for h cycles then release for g cycles; optionally expect a strobe.
  task automatic press(input string n, input logic [3:0] d, input int h, input int g,
                       input bit expect_it, input logic [8:0] e);
    exp_t it;
    valid  = 1'b1;
    number = d;
    if (expect_it) begin
      it.v    = e;
      it.cyc  = cyc + DEB;
      it.name = n;
      sb_q.push_back(it);
    end
    repeat (h) tick();
    valid = 1'b0;
    repeat (g) tick();
  endtask

  task automatic key(input string n, input logic [3:0] d, input logic [8:0] e);
    press(n, d, 6, 5, 1'b1, e);
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit done;
    reset  = 1'b1;
    valid  = 1'b0;
    number = 4'd0;
    relock = 1'b0;
    tick();
    tick();
    probe("reset_state", 0, ev(0,0,0,0,0,0), 0);
    reset = 1'b0;
    idle(5);

    // Correct code, then digits ignored while open, then relock
    key("code1_d1", 4'd1, ev(1,0,1,0,0,0));
    key("code1_d2", 4'd2, ev(1,0,2,0,0,0));
    key("code1_d3", 4'd3, ev(1,0,3,0,0,0));
    key("code1_d4", 4'd4, ev(1,0,0,1,0,0));
    probe("open_state", 0, ev(0,0,0,1,0,0), 0);
    press("open_digit", 4'd7, 6, 5, 1'b0, '0);
    probe("open_ignores_digit", 0, ev(0,0,0,1,0,0), 0);
    pulse_relock();
    probe("relock_from_open", 0, ev(0,0,0,0,0,0), 0);

    // Partial entry cleared by relock, then full code
    key("part_d1", 4'd1, ev(1,0,1,0,0,0));
    key("part_d2", 4'd2, ev(1,0,2,0,0,0));
    pulse_relock();
    probe("relock_partial", 0, ev(0,0,0,0,0,0), 0);
    key("code2_d1", 4'd1, ev(1,0,1,0,0,0));
    key("code2_d2", 4'd2, ev(1,0,2,0,0,0));
    key("code2_d3", 4'd3, ev(1,0,3,0,0,0));
    key("code2_d4", 4'd4, ev(1,0,0,1,0,0));
    pulse_relock();

    // Bounce: toggling gives nothing, 4 stable cycles give one strobe
    number = 4'd7;
    valid = 1'b1; tick();
    valid = 1'b0; tick();
    valid = 1'b1; tick();
    valid = 1'b0; tick();
    press("bounce7", 4'd7, 4, 5, 1'b1, ev(1,0,1,0,0,0));
    pulse_relock();

    // Held key, short release does not re-arm, full release does
    press("held5_first", 4'd5, 40, 3, 1'b1, ev(1,0,1,0,0,0));
    press("held5_short", 4'd5, 6, 4, 1'b0, '0);
    press("held5_second", 4'd5, 6, 5, 1'b1, ev(1,0,2,0,0,0));
    pulse_relock();

    // Three wrong entries -> lockout
    for (int a = 1; a <= 3; a++) begin
      key("wrong_d1", 4'd9, ev(1,0,1,0,0,a-1));
      key("wrong_d2", 4'd9, ev(1,0,2,0,0,a-1));
      key("wrong_d3", 4'd9, ev(1,0,3,0,0,a-1));
      key("wrong_d4", 4'd9, ev(1,1,0,0,(a == 3),(a == 3) ? 0 : a));
    end
    pulse_relock();
    probe("lockout_ignores_relock", 0, ev(0,0,0,0,1,0), 0);
    for (int p = 0; p < 3; p++) press("lockout_press", 4'd1, 6, 5, 1'b0, '0);
    done = 1'b0;
    for (int w = 0; w < 100; w++) begin
      if (!lockout) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) probe("lockout_end_wait", 2, '0, 0);
    probe("lockout_length", 1, '0, 64);
    probe("after_lockout", 0, ev(0,0,0,0,0,0), 0);
    idle(5);
    key("code3_d1", 4'd1, ev(1,0,1,0,0,0));
    key("code3_d2", 4'd2, ev(1,0,2,0,0,0));
    key("code3_d3", 4'd3, ev(1,0,3,0,0,0));
    key("code3_d4", 4'd4, ev(1,0,0,1,0,0));
    pulse_relock();

    // Reset mid-operation clears failure history and partial entry
    for (int a = 1; a <= 2; a++) begin
      key("pre_d1", 4'd9, ev(1,0,1,0,0,a-1));
      key("pre_d2", 4'd9, ev(1,0,2,0,0,a-1));
      key("pre_d3", 4'd9, ev(1,0,3,0,0,a-1));
      key("pre_d4", 4'd9, ev(1,1,0,0,0,a));
    end
    key("pre_p1", 4'd1, ev(1,0,1,0,0,2));
    key("pre_p2", 4'd2, ev(1,0,2,0,0,2));
    reset = 1'b1;
    tick();
    probe("reset_mid", 0, ev(0,0,0,0,0,0), 0);
    reset = 1'b0;
    idle(5);
    key("post_d1", 4'd9, ev(1,0,1,0,0,0));
    key("post_d2", 4'd9, ev(1,0,2,0,0,0));
    key("post_d3", 4'd9, ev(1,0,3,0,0,0));
    key("post_d4", 4'd9, ev(1,1,0,0,0,1));
    probe("post_reset_no_lockout", 0, ev(0,0,0,0,0,1), 0);

    idle(5);
    probe("scoreboard_drained", 3, '0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
